am_sample_scheduler: RTL
========================

# am_sample_scheduler

Two-source sample scheduler that sits between the sample FIFOs and the AM PWM modulator. It arbitrates two first-word-fall-through sample FIFOs, fixed-priority or round-robin, into a one-entry holding buffer. The buffer is presented to the modulator as a FIFO-like interface. On underrun it can insert a configurable idle level (carrier-only) sample and counts such events.

## Interface
- IDLE_LEVEL, 8'd128, sample loaded on underrun (50 % duty, unmodulated carrier)
- STAT_WIDTH, 16, width of saturating statistics counters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  allows new loads into the buffer; consumption is always honoured
- rr_mode  in  1  0: src0 fixed priority, 1: round-robin
- fill_en  in  1  enables idle-level insertion on underrun
- clr_stats  in  1  synchronous clear of all statistics counters
- src0_sample  in  8  head of FIFO 0 (valid while src0_empty=0)
- src0_empty  in  1  FIFO 0 empty
- src0_read  out  1  one-cycle pop pulse to FIFO 0
- src1_sample, src1_empty, src1_read: same as src0 for FIFO 1
- mod_sample  out  8  buffer contents
- mod_empty  out  1  buffer holds no sample
- mod_read  in  1  one-cycle pop pulse from modulator
- grant  out  2  one-hot source of the current buffer entry; 2'b00 for fill/empty
- underrun_count, src0_count, src1_count  out  STAT_WIDTH  saturating counters

## Operation
- Read protocol on both sides: the consumer captures data at edge E and drives read high in cycle E..E+1. The producer pops at edge E+1.
- States: ST_EMPTY (buffer invalid), ST_DATA (buffer holds a source sample), ST_FILL (buffer holds IDLE_LEVEL).
- Consume: at an edge with mod_read=1 and state≠ST_EMPTY, the entry is consumed. mod_read in ST_EMPTY is ignored.
- Buffer free at an edge = state==ST_EMPTY, or a consume occurs at that edge.
- Source eligible = srcN_empty==0 and srcN_read==0, i.e. not in its pop-pending cycle.
- Load at edge, when enable=1 and the buffer is free:
  - One eligible source: capture its sample, pulse its read, state→ST_DATA, grant=its bit, increment its count.
  - Both eligible, rr_mode=0: src0 wins.
  - Both eligible, rr_mode=1: the source not granted last wins. The last-grant pointer updates only on source loads.
  - None eligible and fill_en=1: buf←IDLE_LEVEL, state→ST_FILL, grant=0, underrun_count+1. No source read.
  - None eligible and fill_en=0: state→ST_EMPTY.
- A fill entry is never preempted by a source sample; it must be consumed first. This guarantees at most one fill per consumed sample.
- A consume with enable=0 → state→ST_EMPTY, mod_sample holds its last value.
- Counters saturate at all-ones. clr_stats zeroes them, and takes priority over a simultaneous increment.

## Timing
- Reset values: state ST_EMPTY, mod_empty=1, mod_sample=0, src0_read=src1_read=0, grant=0, all counters 0, last-grant pointer=src1 (so src0 wins the first tie).
- All outputs are registered. mod_empty = (state==ST_EMPTY).
- Latency from source non-empty to mod_empty=0: one edge.
- Back-to-back: a consume and a refill occur on the same edge, so mod_empty stays 0 when data is available.
- The same source can be loaded at most every second cycle because of its pop-pending cycle.
- rst mid-operation: the buffer is discarded and any pending pulse is dropped at that edge. A source whose pop pulse is cut keeps its head sample.

## Structure
- Shared project defines/package: state encodings, default IDLE_LEVEL, STAT_WIDTH.
- One sub-module, am_rr_arbiter2:
  - inputs: two request bits, mode, advance strobe
  - outputs: one-hot grant, and the registered last-grant pointer
- Statistics counters stay inline.

## Test plan
- Reset, then src0 loaded with 0x40 → one edge later mod_empty=0, mod_sample=0x40, src0_read pulses one cycle, grant=01, src0_count=1.
- Both FIFOs hold 4 samples, rr_mode=1, modulator pops every 3 cycles → grants alternate 01,10,01,…; src0_count=src1_count=4; no sample is lost or duplicated.
- Same as above with rr_mode=0 → all src0 samples are delivered before any src1 sample.
- Both FIFOs empty, fill_en=1 → mod_sample=0x80, grant=00, underrun_count increments once per mod_read, not per cycle. With fill_en=0 → mod_empty stays 1 and the count is unchanged.
- Fill entry in buffer, then src1 becomes non-empty before mod_read → the fill is delivered first and src1's sample follows on the consume edge.
- underrun_count preset near 0xFFFF via repeated fills → it saturates. clr_stats together with a fill event → 0. rst during src0_read high → next cycle all outputs are at reset values.

Source files
------------

// File: rtl/am_sample_scheduler_pkg.sv
// Shared definitions for the AM sample scheduler: buffer states, grant codes
// and default parameter values.
package am_sample_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_DATA  = 2'd1,
        ST_FILL  = 2'd2
    } sched_state_e;

    typedef logic [1:0] grant_t;

    localparam grant_t GNT_NONE = 2'b00;
    localparam grant_t GNT_SRC0 = 2'b01;
    localparam grant_t GNT_SRC1 = 2'b10;

    // Unmodulated carrier: 50 % PWM duty.
    localparam logic [7:0] IDLE_LEVEL_DEFAULT = 8'd128;
    localparam int unsigned STAT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/am_sample_scheduler_if.sv
// Sample path between the two source FIFOs, the scheduler and the modulator.
// The slave modport is the scheduler's view; master is the surrounding FIFOs/modulator.
interface am_sample_scheduler_if;
    import am_sample_scheduler_pkg::*;

    logic [7:0] src0_sample;
    logic       src0_empty;
    logic       src0_read;
    logic [7:0] src1_sample;
    logic       src1_empty;
    logic       src1_read;
    logic [7:0] mod_sample;
    logic       mod_empty;
    logic       mod_read;
    grant_t     grant;

    modport master (
        output src0_sample, src0_empty, src1_sample, src1_empty, mod_read,
        input  src0_read, src1_read, mod_sample, mod_empty, grant
    );

    modport slave (
        input  src0_sample, src0_empty, src1_sample, src1_empty, mod_read,
        output src0_read, src1_read, mod_sample, mod_empty, grant
    );

endinterface

// File: rtl/am_rr_arbiter2.sv
// Two-request arbiter: fixed src0 priority or round-robin on a registered
// last-grant pointer that only moves when a grant is actually taken.
module am_rr_arbiter2
    import am_sample_scheduler_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   [1:0] req_i,
    input  logic   mode_i,
    input  logic   advance_i,
    output grant_t gnt_o,
    output logic   last_o
);

    // last_q = 1 means src1 was granted last, so src0 wins the first tie.
    logic last_q;
    logic last_d;

    // One-hot winner selection from the current requests.
    always_comb begin
        gnt_o = GNT_NONE;
        case (req_i)
            2'b01: gnt_o = GNT_SRC0;
            2'b10: gnt_o = GNT_SRC1;
            2'b11: begin
                if (mode_i && !last_q) begin
                    gnt_o = GNT_SRC1;
                end else begin
                    gnt_o = GNT_SRC0;
                end
            end
            default: gnt_o = GNT_NONE;
        endcase
    end

    // Pointer update when the granted source is loaded.
    always_comb begin
        last_d = last_q;
        if (advance_i && (gnt_o != GNT_NONE)) begin
            last_d = gnt_o[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/am_sample_scheduler.sv
// Arbitrates two FWFT sample FIFOs into a one-entry buffer feeding the AM
// modulator, inserting an idle carrier sample on underrun when allowed.
module am_sample_scheduler
    import am_sample_scheduler_pkg::*;
#(
    parameter logic [7:0]  IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
    parameter int unsigned STAT_WIDTH = STAT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  rr_mode_i,
    input  logic                  fill_en_i,
    input  logic                  clr_stats_i,
    am_sample_scheduler_if.slave  sched_if,
    output logic [STAT_WIDTH-1:0] underrun_count_o,
    output logic [STAT_WIDTH-1:0] src0_count_o,
    output logic [STAT_WIDTH-1:0] src1_count_o
);

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    sched_state_e          state_q, state_d;
    logic [7:0]            buf_q, buf_d;
    grant_t                grant_q, grant_d;
    logic                  rd0_q, rd0_d;
    logic                  rd1_q, rd1_d;
    logic                  empty_q, empty_d;
    logic [STAT_WIDTH-1:0] ucnt_q, ucnt_d;
    logic [STAT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [STAT_WIDTH-1:0] cnt1_q, cnt1_d;

    logic   consume;
    logic   buf_free;
    logic   load;
    logic   [1:0] req;
    grant_t arb_gnt;
    logic   inc0, inc1, incu;

    // A source in its pop-pending cycle still shows the old head, so it must not compete.
    always_comb begin
        consume  = sched_if.mod_read && (state_q != ST_EMPTY);
        buf_free = (state_q == ST_EMPTY) || consume;
        load     = enable_i && buf_free;
        req      = {(!sched_if.src1_empty && !rd1_q), (!sched_if.src0_empty && !rd0_q)};
    end

    am_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .mode_i    (rr_mode_i),
        .advance_i (load),
        .gnt_o     (arb_gnt),
        .last_o    ()
    );

    // Buffer state machine: load, fill or drain the single entry.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        grant_d = grant_q;
        rd0_d   = 1'b0;
        rd1_d   = 1'b0;
        inc0    = 1'b0;
        inc1    = 1'b0;
        incu    = 1'b0;
        if (load) begin
            case (arb_gnt)
                GNT_SRC0: begin
                    state_d = ST_DATA;
                    buf_d   = sched_if.src0_sample;
                    grant_d = GNT_SRC0;
                    rd0_d   = 1'b1;
                    inc0    = 1'b1;
                end
                GNT_SRC1: begin
                    state_d = ST_DATA;
                    buf_d   = sched_if.src1_sample;
                    grant_d = GNT_SRC1;
                    rd1_d   = 1'b1;
                    inc1    = 1'b1;
                end
                default: begin
                    grant_d = GNT_NONE;
                    if (fill_en_i) begin
                        state_d = ST_FILL;
                        buf_d   = IDLE_LEVEL;
                        incu    = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                        buf_d   = buf_q;
                    end
                end
            endcase
        end else if (consume) begin
            state_d = ST_EMPTY;
            grant_d = GNT_NONE;
        end else begin
            state_d = state_q;
        end
        empty_d = (state_d == ST_EMPTY);
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_comb begin
        ucnt_d = ucnt_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (clr_stats_i) begin
            ucnt_d = {STAT_WIDTH{1'b0}};
            cnt0_d = {STAT_WIDTH{1'b0}};
            cnt1_d = {STAT_WIDTH{1'b0}};
        end else begin
            ucnt_d = incu ? sat_inc(ucnt_q) : ucnt_q;
            cnt0_d = inc0 ? sat_inc(cnt0_q) : cnt0_q;
            cnt1_d = inc1 ? sat_inc(cnt1_q) : cnt1_q;
        end
    end

    // State, buffer, pulse and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            buf_q   <= 8'd0;
            grant_q <= GNT_NONE;
            rd0_q   <= 1'b0;
            rd1_q   <= 1'b0;
            empty_q <= 1'b1;
            ucnt_q  <= {STAT_WIDTH{1'b0}};
            cnt0_q  <= {STAT_WIDTH{1'b0}};
            cnt1_q  <= {STAT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            grant_q <= grant_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            empty_q <= empty_d;
            ucnt_q  <= ucnt_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign sched_if.src0_read  = rd0_q;
    assign sched_if.src1_read  = rd1_q;
    assign sched_if.mod_sample = buf_q;
    assign sched_if.mod_empty  = empty_q;
    assign sched_if.grant      = grant_q;
    assign underrun_count_o    = ucnt_q;
    assign src0_count_o        = cnt0_q;
    assign src1_count_o        = cnt1_q;

endmodule
